// File: rtl/ysyx_22050058_seqdiv_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050058_seqdiv_if
// Description : EX-stage <-> divider handshake bundle (request, stall, result)
// Revision    : 1.0
// ============================================================================
interface ysyx_22050058_seqdiv_if #(
    parameter int WIDTH = 64
) ();
    logic             div_datavalid_i;
    logic             div_signed_i;
    logic [WIDTH-1:0] div_dividend_i;
    logic [WIDTH-1:0] div_divisor_i;
    logic             div_ready;
    logic             div_flush_i;
    logic             div_doing_o;
    logic             div_qrvalid_o;
    logic [WIDTH-1:0] div_quotient_o;
    logic [WIDTH-1:0] div_remainder_o;

    modport master (
        output div_datavalid_i, div_signed_i, div_dividend_i, div_divisor_i,
               div_ready, div_flush_i,
        input  div_doing_o, div_qrvalid_o, div_quotient_o, div_remainder_o
    );

    modport slave (
        input  div_datavalid_i, div_signed_i, div_dividend_i, div_divisor_i,
               div_ready, div_flush_i,
        output div_doing_o, div_qrvalid_o, div_quotient_o, div_remainder_o
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050058_seqdiv.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050058_seqdiv
// Description : Radix-2 restoring divider, signed/unsigned, one bit per cycle
// Revision    : 1.0
// ============================================================================
module ysyx_22050058_seqdiv #(
    parameter int WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22050058_seqdiv_if.slave       div_bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_doing;
    logic             w_qrvalid;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_q_neg;
    logic             r_r_neg;

    logic             w_accept;
    logic             w_dvs_zero;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_part_next;
    logic [WIDTH-1:0] w_quot_final;
    logic             w_last;

    assign w_accept   = (r_state == S_IDLE) && div_bus.div_datavalid_i && !div_bus.div_flush_i;
    assign w_dvs_zero = (div_bus.div_divisor_i == '0);
    assign w_dvd_neg  = div_bus.div_signed_i && div_bus.div_dividend_i[WIDTH-1];
    assign w_dvs_neg  = div_bus.div_signed_i && div_bus.div_divisor_i[WIDTH-1];
    assign w_dvd_abs  = w_dvd_neg ? -div_bus.div_dividend_i : div_bus.div_dividend_i;
    assign w_dvs_abs  = w_dvs_neg ? -div_bus.div_divisor_i  : div_bus.div_divisor_i;

    // Dividend bits leave r_shift at the top while quotient bits enter at the bottom.
    assign w_shifted    = {r_part, r_shift[WIDTH-1]};
    assign w_trial      = w_shifted - {1'b0, r_dvsr};
    assign w_qbit       = ~w_trial[WIDTH];
    assign w_part_next  = w_qbit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_quot_final = {r_shift[WIDTH-2:0], w_qbit};
    assign w_last       = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_doing      = 1'b0;
        w_qrvalid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_dvs_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_doing = 1'b1;
                if (div_bus.div_flush_i) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_qrvalid = 1'b1;
                if (div_bus.div_flush_i || div_bus.div_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_part  <= '0;
            r_shift <= '0;
            r_dvsr  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (w_accept) begin
            r_part  <= '0;
            r_shift <= w_dvd_abs;
            r_dvsr  <= w_dvs_abs;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
            if (w_dvs_zero) begin
                r_cnt  <= '0;
                r_quot <= '1;
                r_rem  <= div_bus.div_dividend_i;
            end else begin
                r_cnt  <= CW'(WIDTH);
            end
        end else if (r_state == S_BUSY) begin
            if (div_bus.div_flush_i) begin
                r_cnt <= '0;
            end else begin
                r_part  <= w_part_next;
                r_shift <= w_quot_final;
                r_cnt   <= r_cnt - CW'(1);
                if (w_last) begin
                    r_quot <= r_q_neg ? -w_quot_final : w_quot_final;
                    r_rem  <= r_r_neg ? -w_part_next  : w_part_next;
                end
            end
        end
    end

    assign div_bus.div_doing_o     = w_doing;
    assign div_bus.div_qrvalid_o   = w_qrvalid;
    assign div_bus.div_quotient_o  = r_quot;
    assign div_bus.div_remainder_o = r_rem;

endmodule
`default_nettype wire
